// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold / load / shift left / shift right, plus an
// auto-shift engine (IDLE/RUN) with Busy/Done. Define USR_ROTATE_EN to make auto-shifts rotate.
module universal_shift_reg #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        Mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              ShiftInLsb,
  input  logic              ShiftInMsb,
  input  logic              Start,
  input  logic [STEP_W-1:0] Steps,
  input  logic              Dir,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qp,
  output logic              SerialOutMsb,
  output logic              SerialOutLsb,
  output logic              Busy,
  output logic              Done,
  output logic [0:0]        state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [0:0]        state;
  logic [STEP_W-1:0] cnt;
  logic              dir_lat;
  logic [WIDTH-1:0]  man_shl;
  logic [WIDTH-1:0]  man_shr;
  logic [WIDTH-1:0]  auto_shl;
  logic [WIDTH-1:0]  auto_shr;

  always_comb begin
    man_shl = {Q[WIDTH-2:0], ShiftInLsb};
    man_shr = {ShiftInMsb, Q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
    auto_shl = {Q[WIDTH-2:0], Q[WIDTH-1]};
    auto_shr = {Q[0], Q[WIDTH-1:1]};
`else
    auto_shl = man_shl;
    auto_shr = man_shr;
`endif
  end

  // Start beats Mode in IDLE; in RUN both Start and Mode are ignored.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q       <= '0;
      state   <= IDLE;
      cnt     <= '0;
      dir_lat <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            cnt     <= Steps;
            dir_lat <= Dir;
            state   <= RUN;
          end else begin
            case (Mode)
              MODE_HOLD: Q <= Q;
              MODE_SHL:  Q <= man_shl;
              MODE_SHR:  Q <= man_shr;
              MODE_LOAD: Q <= D;
              default:   Q <= Q;
            endcase
          end
        end
        RUN: begin
          if (cnt != '0) begin
            Q   <= dir_lat ? auto_shr : auto_shl;
            cnt <= cnt - {{(STEP_W-1){1'b0}}, 1'b1};
          end else begin
            state <= IDLE;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy         = (state == RUN);
  assign Qp           = ~Q;
  assign SerialOutMsb = Q[WIDTH-1];
  assign SerialOutLsb = Q[0];
  assign state_dbg    = state;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg: manual modes, auto-shift timing,
// ignored inputs while busy, reset abort and back-to-back operations.
module tb_universal_shift_reg;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              Clock;
  logic              Reset;
  logic [1:0]        Mode;
  logic [WIDTH-1:0]  D;
  logic              ShiftInLsb;
  logic              ShiftInMsb;
  logic              Start;
  logic [STEP_W-1:0] Steps;
  logic              Dir;
  logic [WIDTH-1:0]  Q;
  logic [WIDTH-1:0]  Qp;
  logic              SerialOutMsb;
  logic              SerialOutLsb;
  logic              Busy;
  logic              Done;
  logic [0:0]        state_dbg;

  int vectors;
  int miscompares;
  logic [WIDTH-1:0] exp_q[$];

  universal_shift_reg #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .D(D),
    .ShiftInLsb(ShiftInLsb), .ShiftInMsb(ShiftInMsb),
    .Start(Start), .Steps(Steps), .Dir(Dir),
    .Q(Q), .Qp(Qp), .SerialOutMsb(SerialOutMsb), .SerialOutLsb(SerialOutLsb),
    .Busy(Busy), .Done(Done), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_op(input logic [STEP_W-1:0] n, input logic dir);
    Start = 1'b1;
    Steps = n;
    Dir   = dir;
    tick();
    Start = 1'b0;
  endtask

  logic [WIDTH-1:0] e;
  int n;
  int busy_cnt;
  int done_cnt;

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1'b1; Mode = 2'b11; D = 8'hFF; ShiftInLsb = 1'b0; ShiftInMsb = 1'b0;
    Start = 1'b0; Steps = '0; Dir = 1'b0;

    // reset
    tick(); tick();
    check("rst_q", Q, 8'h00);
    check("rst_qp", Qp, 8'hFF);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_state", state_dbg, 1'b0);
    Reset = 1'b0;

    // manual modes
    Mode = 2'b11; D = 8'hA5; tick();
    check("load_q", Q, 8'hA5);
    Mode = 2'b01; ShiftInLsb = 1'b1; tick();
    check("shl_q", Q, 8'h4B);
    check("shl_smsb", SerialOutMsb, 1'b0);
    check("shl_slsb", SerialOutLsb, 1'b1);
    Mode = 2'b10; ShiftInMsb = 1'b0; tick();
    check("shr_q", Q, 8'h25);
    check("shr_qp", Qp, 8'hDA);
    Mode = 2'b00; tick();
    check("hold_q", Q, 8'h25);
    check("hold_slsb", SerialOutLsb, 1'b1);

    // auto-shift left 3 from 81
    Mode = 2'b11; D = 8'h81; tick();
    Mode = 2'b00; ShiftInLsb = 1'b0;
`ifdef USR_ROTATE_EN
    exp_q.push_back(8'h81); exp_q.push_back(8'h03); exp_q.push_back(8'h06); exp_q.push_back(8'h0C);
`else
    exp_q.push_back(8'h81); exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
`endif
    start_op(4'd3, 1'b0);
    busy_cnt = 0;
    while (Busy && busy_cnt < 50) begin
      busy_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check("auto_step_q", Q, e);
      tick();
    end
    check("auto_busy_cycles", busy_cnt, 4);
    check("auto_done", Done, 1'b1);
`ifdef USR_ROTATE_EN
    check("auto_q", Q, 8'h0C);
`else
    check("auto_q", Q, 8'h08);
`endif
    tick();
    check("auto_done_pulse", Done, 1'b0);
    e = Q;

    // Steps = 0
    start_op(4'd0, 1'b0);
    check("z_busy", Busy, 1'b1);
    tick();
    check("z_busy_drop", Busy, 1'b0);
    check("z_done", Done, 1'b1);
    check("z_q", Q, e);
    tick();
    check("z_done_pulse", Done, 1'b0);

    // Steps = 5 right with Mode=11 and Start presented mid-run
    ShiftInMsb = 1'b1;
    start_op(4'd5, 1'b1);
    busy_cnt = Busy ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) begin Mode = 2'b11; D = 8'hFF; Start = 1'b1; Steps = 4'd1; end
      if (i == 1) begin Mode = 2'b00; Start = 1'b0; end
      tick();
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    check("ign_busy_cycles", busy_cnt, 6);
    check("ign_done_count", done_cnt, 1);
`ifdef USR_ROTATE_EN
    check("ign_q", Q, 8'h40);
`else
    check("ign_q", Q, 8'hF8);
`endif

    // reset mid-run
    ShiftInLsb = 1'b1;
    start_op(4'd7, 1'b0);
    tick(); tick(); tick();
    check("mid_busy", Busy, 1'b1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("mid_rst_q", Q, 8'h00);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);

    // Start after reset runs normally
    Mode = 2'b11; D = 8'h81; tick(); Mode = 2'b00;
    start_op(4'd2, 1'b0);
    busy_cnt = 0;
    while (Busy && busy_cnt < 50) begin busy_cnt++; tick(); end
    check("post_busy_cycles", busy_cnt, 3);
    check("post_done", Done, 1'b1);
`ifdef USR_ROTATE_EN
    check("post_q", Q, 8'h06);
`else
    check("post_q", Q, 8'h07);
`endif
    tick();

    // back-to-back: second Start issued in the Done cycle
    ShiftInMsb = 1'b0; ShiftInLsb = 1'b0;
    start_op(4'd2, 1'b1);
    n = 0;
    while (!Done && n < 50) begin n++; tick(); end
    check("b2b_first_done", Done, 1'b1);
`ifdef USR_ROTATE_EN
    check("b2b_first_q", Q, 8'h81);
`else
    check("b2b_first_q", Q, 8'h01);
`endif
    start_op(4'd3, 1'b0);
    check("b2b_busy_again", Busy, 1'b1);
    check("b2b_done_low", Done, 1'b0);
    n = 1;
    while (!Done && n < 50) begin n++; tick(); end
    check("b2b_latency", n, 5);
`ifdef USR_ROTATE_EN
    check("b2b_q", Q, 8'h0C);
`else
    check("b2b_q", Q, 8'h08);
`endif
    check("b2b_busy_drop", Busy, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised N-bit register with complementary outputs, the successor to the single-bit D storage element in the storage-primitives library. It adds hold, parallel-load and bidirectional serial-shift modes, plus an auto-shift engine that performs a programmed number of shifts under a small state machine with Busy/Done handshake. It sits between parallel datapaths and serial links, such as SPI-style serialisers and bit-reversal stages.

## Interface
- WIDTH, 8, register width in bits (≥2)
- STEP_W, 4, width of the auto-shift step count; maximum steps = 2^STEP_W−1
- Clock  in  1  rising-edge clock; one clock for the whole block
- Reset  in  1  synchronous, active-high reset
- Mode  in  2  manual operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load
- D  in  WIDTH  parallel load data
- ShiftInLsb  in  1  bit entering Q[0] on a left shift
- ShiftInMsb  in  1  bit entering Q[WIDTH-1] on a right shift
- Start  in  1  single-cycle request for an auto-shift operation
- Steps  in  STEP_W  number of shifts for the auto-shift operation, sampled with Start
- Dir  in  1  auto-shift direction: 0 left, 1 right, sampled with Start
- Q  out  WIDTH  register contents
- Qp  out  WIDTH  bitwise complement of Q, combinational
- SerialOutMsb  out  1  Q[WIDTH-1]
- SerialOutLsb  out  1  Q[0]
- Busy  out  1  auto-shift in progress; manual Mode ignored
- Done  out  1  one-cycle pulse at the end of an auto-shift

## Operation
- Shift left: Q ← {Q[WIDTH-2:0], ShiftInLsb}. Shift right: Q ← {ShiftInMsb, Q[WIDTH-1:1]}.
- FSM states: IDLE, RUN.
- IDLE: if Start=1, latch Steps into the counter and Dir into the direction register, then go to RUN. Start takes priority over Mode in the same cycle, so Q is unchanged on that edge. If Start=0, apply Mode.
- RUN: if counter≠0, shift one bit in the latched direction and decrement the counter. If counter=0, go to IDLE and register Done=1.
- Serial inputs are sampled on every RUN shift edge, the same as in manual mode.
- Start while Busy=1 is ignored and is not queued. Mode is ignored while Busy=1.
- Reset has priority over everything: Q=0, state=IDLE, counter=0, Busy=0, Done=0, Qp=all ones. A reset mid-operation aborts the shift with no Done pulse.
- Counter arithmetic is unsigned STEP_W-bit. It never wraps, because decrement happens only when the counter is nonzero.

## Timing
- All state updates on the rising edge of Clock. Q changes on the edge where Mode or a shift is sampled, so manual latency is 1 cycle.
- Busy = (state==RUN), registered.
- Start sampled at edge k with Steps=N:
  - Busy is high after edge k.
  - Shifts occur at edges k+1 … k+N.
  - State returns to IDLE at edge k+N+1. Busy drops and Done is high for exactly the cycle following edge k+N+1.
- Steps=0: Busy is high for 1 cycle, there are no shifts, and Done pulses after edge k+1.
- A new Start is accepted in the cycle where Done=1. Back-to-back operations therefore cost N+2 cycles each.
- Qp, SerialOutMsb and SerialOutLsb are combinational from Q and add no latency.

## Configuration
- USR_ROTATE_EN defined: auto-shift operations rotate. On a left shift Q[WIDTH-1] enters Q[0]; on a right shift Q[0] enters Q[WIDTH-1]. ShiftInLsb and ShiftInMsb are ignored during RUN. Manual shifts still use the serial inputs.
- Not defined: auto-shift uses ShiftInLsb/ShiftInMsb exactly like manual shifts.

## Test plan
- Reset: hold Reset for 2 cycles with Mode=11, D=8'hFF. Required: Q=8'h00, Qp=8'hFF, Busy=0, Done=0.
- Manual modes: Load 8'hA5, then shift left with ShiftInLsb=1, then shift right with ShiftInMsb=0, then hold. Required: Q=8'h4B, then 8'h25, then 8'h25 unchanged. SerialOutMsb and SerialOutLsb track Q.
- Auto-shift: Load 8'h81, then Start with Steps=3, Dir=0, ShiftInLsb=0. Required:
  - Busy is high for 4 cycles.
  - Q=8'h08 when Done pulses.
  - With USR_ROTATE_EN defined, Q=8'h0C instead.
- Steps=0 and ignored inputs: Start with Steps=0. Required: Busy for 1 cycle, Done pulses, Q unchanged. During a Steps=5 run, assert Mode=11 and Start. Required: both ignored, and only one Done pulse.
- Reset mid-run: Start with Steps=7, then assert Reset after 3 shifts. Required: Q=0, Busy=0, and no Done pulse. A Start issued after reset runs normally.
- Back-to-back: Issue Start in the same cycle that Done=1. Required: the new operation is accepted, Busy re-asserts on the next edge, and the second Done arrives Steps+2 cycles later.
